// File: rtl/sha1_pkg.sv
// Shared constants, FSM state type and tail-block builder for the SHA-1 message padder.
package sha1_pkg;

  localparam int unsigned SHA1_BLOCK_BYTES = 64;
  localparam int unsigned SHA1_LEN_OFS     = 56;
  localparam logic [7:0]  SHA1_PAD_BYTE    = 8'h80;
  localparam int unsigned SHA1_BLOCK_W     = 512;
  localparam int unsigned SHA1_LEN_W       = 64;

  typedef enum logic [1:0] {
    S_FILL = 2'd0,
    S_OUT  = 2'd1,
    S_TAIL = 2'd2
  } sha1_state_e;

  // Padding-only final block: optional leading 0x80, zeros, then the bit length.
  function automatic logic [SHA1_BLOCK_W-1:0] sha1_tail_block(input logic            lead_pad,
                                                              input logic [SHA1_LEN_W-1:0] len);
    return {(lead_pad ? SHA1_PAD_BYTE : 8'h00), 440'd0, len};
  endfunction

endpackage

// File: rtl/sha1_padder_if.sv
// Byte-stream input and 512-bit block output handshakes of the SHA-1 padder.
interface sha1_padder_if;
  import sha1_pkg::*;

  logic                    in_valid_i;
  logic [7:0]              in_data_i;
  logic                    in_last_i;
  logic                    in_empty_i;
  logic                    in_ready_o;
  logic                    blk_valid_o;
  logic                    blk_ready_i;
  logic [SHA1_BLOCK_W-1:0] blk_data_o;
  logic                    blk_last_o;

  modport master (
    output in_valid_i, in_data_i, in_last_i, in_empty_i, blk_ready_i,
    input  in_ready_o, blk_valid_o, blk_data_o, blk_last_o
  );

  modport slave (
    input  in_valid_i, in_data_i, in_last_i, in_empty_i, blk_ready_i,
    output in_ready_o, blk_valid_o, blk_data_o, blk_last_o
  );

endinterface

// File: rtl/sha1_padder.sv
// Packs a byte stream into big-endian 512-bit SHA-1 blocks, appending 0x80,
// zero fill and the 64-bit message bit length, with an extra tail block when needed.
module sha1_padder
  import sha1_pkg::*;
#(
  parameter int unsigned CNT_W = 61
) (
  input logic           clk_i,
  input logic           rst_i,
  sha1_padder_if.slave  bus
);

  localparam int unsigned IDX_W = 6;
  localparam int unsigned P_W   = 7;

  sha1_state_e             r_state;
  logic [IDX_W-1:0]        r_idx;
  logic [CNT_W-1:0]        r_cnt;
  logic [SHA1_BLOCK_W-1:0] r_buf;
  logic [SHA1_LEN_W-1:0]   r_len;
  logic                    r_last;
  logic                    r_tail_pend;
  logic                    r_tail_pad;
  logic                    r_in_ready;
  logic                    r_blk_valid;

  logic                    w_acc;
  logic                    w_byte;
  logic [P_W-1:0]          w_p;
  logic [CNT_W-1:0]        w_cnt_nxt;
  logic [SHA1_LEN_W-1:0]   w_len;
  logic [SHA1_BLOCK_W-1:0] w_buf;
  logic                    w_fits;

  // Buffer image after this beat's byte write and, on a last beat, its padding.
  always_comb begin
    w_acc     = bus.in_valid_i && r_in_ready;
    w_byte    = w_acc && !bus.in_empty_i;
    w_p       = {1'b0, r_idx} + P_W'(w_byte);
    w_cnt_nxt = r_cnt + CNT_W'(w_byte);
    w_len     = SHA1_LEN_W'({w_cnt_nxt, 3'b000});
    w_fits    = w_p < P_W'(SHA1_LEN_OFS);
    w_buf     = r_buf;
    for (int i = 0; i < int'(SHA1_BLOCK_BYTES); i++) begin
      if (w_byte && (r_idx == IDX_W'(i))) begin
        w_buf[511 - 8*i -: 8] = bus.in_data_i;
      end
    end
    // Bytes past p are already zero: the buffer is cleared after every block.
    for (int i = 0; i < int'(SHA1_BLOCK_BYTES); i++) begin
      if (bus.in_last_i && (w_p == P_W'(i))) begin
        w_buf[511 - 8*i -: 8] = SHA1_PAD_BYTE;
      end
    end
    if (bus.in_last_i && w_fits) begin
      w_buf[SHA1_LEN_W-1:0] = w_len;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state     <= S_FILL;
      r_idx       <= '0;
      r_cnt       <= '0;
      r_buf       <= '0;
      r_len       <= '0;
      r_last      <= 1'b0;
      r_tail_pend <= 1'b0;
      r_tail_pad  <= 1'b0;
      r_in_ready  <= 1'b1;
      r_blk_valid <= 1'b0;
    end else begin
      case (r_state)
        S_FILL: begin
          if (w_acc && bus.in_last_i) begin
            r_buf       <= w_buf;
            r_cnt       <= w_cnt_nxt;
            r_len       <= w_len;
            r_idx       <= '0;
            r_last      <= w_fits;
            r_tail_pend <= !w_fits;
            r_tail_pad  <= (w_p == P_W'(SHA1_BLOCK_BYTES));
            r_state     <= S_OUT;
            r_in_ready  <= 1'b0;
            r_blk_valid <= 1'b1;
          end else if (w_byte) begin
            r_buf <= w_buf;
            r_cnt <= w_cnt_nxt;
            r_idx <= r_idx + IDX_W'(1);
            if (r_idx == IDX_W'(SHA1_BLOCK_BYTES - 1)) begin
              r_last      <= 1'b0;
              r_tail_pend <= 1'b0;
              r_state     <= S_OUT;
              r_in_ready  <= 1'b0;
              r_blk_valid <= 1'b1;
            end
          end
        end
        S_OUT: begin
          if (bus.blk_ready_i) begin
            if (r_tail_pend) begin
              r_buf       <= sha1_tail_block(r_tail_pad, r_len);
              r_last      <= 1'b1;
              r_tail_pend <= 1'b0;
              r_state     <= S_TAIL;
            end else begin
              r_buf       <= '0;
              r_idx       <= '0;
              r_last      <= 1'b0;
              r_state     <= S_FILL;
              r_in_ready  <= 1'b1;
              r_blk_valid <= 1'b0;
              if (r_last) begin
                r_cnt <= '0;
              end
            end
          end
        end
        S_TAIL: begin
          if (bus.blk_ready_i) begin
            r_buf       <= '0;
            r_idx       <= '0;
            r_cnt       <= '0;
            r_last      <= 1'b0;
            r_state     <= S_FILL;
            r_in_ready  <= 1'b1;
            r_blk_valid <= 1'b0;
          end
        end
        default: begin
          r_buf       <= '0;
          r_idx       <= '0;
          r_cnt       <= '0;
          r_last      <= 1'b0;
          r_tail_pend <= 1'b0;
          r_state     <= S_FILL;
          r_in_ready  <= 1'b1;
          r_blk_valid <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready_o  = r_in_ready;
  assign bus.blk_valid_o = r_blk_valid;
  assign bus.blk_data_o  = r_buf;
  assign bus.blk_last_o  = r_last;

endmodule

// File: tb/tb_sha1_padder.sv
// Directed self-checking bench for sha1_padder: padding boundaries, backpressure and reset.
module tb_sha1_padder;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sha1_padder_if bus_if ();

  sha1_padder #(.CNT_W(61)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus_if)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_beat(input logic [7:0] d, input logic last, input logic empty);
    int n = 0;
    bus_if.in_valid_i = 1'b1;
    bus_if.in_data_i  = d;
    bus_if.in_last_i  = last;
    bus_if.in_empty_i = empty;
    while (!bus_if.in_ready_o && n < 500) begin
      step();
      n++;
    end
    if (!bus_if.in_ready_o) begin
      n_tests++;
      n_fail++;
      $display("FAIL send_beat_timeout: in_ready_o=%b required 1", bus_if.in_ready_o);
    end
    step();
    bus_if.in_valid_i = 1'b0;
    bus_if.in_last_i  = 1'b0;
    bus_if.in_empty_i = 1'b0;
  endtask

  // Bytes are 1,2,3,... so every position is distinguishable.
  task automatic send_msg(input int n, input logic last);
    if (n == 0 && last) send_beat(8'h00, 1'b1, 1'b1);
    for (int i = 0; i < n; i++) send_beat(8'(i + 1), last && (i == n - 1), 1'b0);
  endtask

  task automatic get_block(output logic [511:0] d, output logic l);
    int n = 0;
    bus_if.blk_ready_i = 1'b1;
    while (!bus_if.blk_valid_o && n < 500) begin
      step();
      n++;
    end
    if (!bus_if.blk_valid_o) begin
      n_tests++;
      n_fail++;
      $display("FAIL get_block_timeout: blk_valid_o=%b required 1", bus_if.blk_valid_o);
    end
    d = bus_if.blk_data_o;
    l = bus_if.blk_last_o;
    step();
    bus_if.blk_ready_i = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    n_tests++; if (bus_if.in_ready_o !== 1'b1) begin n_fail++; $display("FAIL rst_in_ready: got %b required 1", bus_if.in_ready_o); end
    n_tests++; if (bus_if.blk_valid_o !== 1'b0) begin n_fail++; $display("FAIL rst_blk_valid: got %b required 0", bus_if.blk_valid_o); end
    n_tests++; if (bus_if.blk_last_o !== 1'b0) begin n_fail++; $display("FAIL rst_blk_last: got %b required 0", bus_if.blk_last_o); end
    n_tests++; if (bus_if.blk_data_o !== 512'd0) begin n_fail++; $display("FAIL rst_blk_data: got %h required 0", bus_if.blk_data_o); end
    rst = 1'b0;
    step();
  endtask

  task automatic test_empty();
    logic [511:0] d, exp;
    logic l;
    exp = '0;
    exp[511:504] = 8'h80;
    send_beat(8'h00, 1'b1, 1'b1);
    n_tests++; if (bus_if.blk_valid_o !== 1'b1) begin n_fail++; $display("FAIL empty_latency: blk_valid_o=%b required 1", bus_if.blk_valid_o); end
    get_block(d, l);
    n_tests++; if (d !== exp) begin n_fail++; $display("FAIL empty_data: got %h required %h", d, exp); end
    n_tests++; if (l !== 1'b1) begin n_fail++; $display("FAIL empty_last: got %b required 1", l); end
  endtask

  task automatic test_abc(input string tag);
    logic [511:0] d, exp;
    logic l;
    exp = '0;
    exp[511:480] = 32'h61626380;
    exp[63:0]    = 64'h18;
    send_beat(8'h61, 1'b0, 1'b0);
    send_beat(8'h62, 1'b0, 1'b0);
    send_beat(8'h63, 1'b1, 1'b0);
    n_tests++; if (bus_if.blk_valid_o !== 1'b1) begin n_fail++; $display("FAIL %s_latency: blk_valid_o=%b required 1", tag, bus_if.blk_valid_o); end
    get_block(d, l);
    n_tests++; if (d !== exp) begin n_fail++; $display("FAIL %s_data: got %h required %h", tag, d, exp); end
    n_tests++; if (l !== 1'b1) begin n_fail++; $display("FAIL %s_last: got %b required 1", tag, l); end
    n_tests++; if (bus_if.in_ready_o !== 1'b1) begin n_fail++; $display("FAIL %s_refill: in_ready_o=%b required 1", tag, bus_if.in_ready_o); end
  endtask

  task automatic test_empty_ignored();
    logic [511:0] d, exp;
    logic l;
    exp = '0;
    exp[511:480] = 32'h61626380;
    exp[63:0]    = 64'h18;
    send_beat(8'h61, 1'b0, 1'b0);
    send_beat(8'hFF, 1'b0, 1'b1);
    send_beat(8'h62, 1'b0, 1'b0);
    send_beat(8'h63, 1'b1, 1'b0);
    get_block(d, l);
    n_tests++; if (d !== exp || l !== 1'b1) begin n_fail++; $display("FAIL empty_ignored: got %h/%b required %h/1", d, l, exp); end
  endtask

  task automatic test_55();
    logic [511:0] d, exp;
    logic l;
    exp = '0;
    for (int i = 0; i < 55; i++) exp[511 - 8*i -: 8] = 8'(i + 1);
    exp[511 - 8*55 -: 8] = 8'h80;
    exp[63:0] = 64'h1B8;
    send_msg(55, 1'b1);
    get_block(d, l);
    n_tests++; if (d !== exp) begin n_fail++; $display("FAIL len55_data: got %h required %h", d, exp); end
    n_tests++; if (l !== 1'b1) begin n_fail++; $display("FAIL len55_last: got %b required 1", l); end
  endtask

  task automatic test_back_to_back();
    logic [511:0] d1, d2, exp1, exp2;
    logic l1, l2, v2;
    int n = 0;
    exp1 = '0;
    for (int i = 0; i < 56; i++) exp1[511 - 8*i -: 8] = 8'(i + 1);
    exp1[511 - 8*56 -: 8] = 8'h80;
    exp2 = '0;
    exp2[63:0] = 64'h1C0;
    send_msg(56, 1'b1);
    bus_if.blk_ready_i = 1'b1;
    while (!bus_if.blk_valid_o && n < 500) begin step(); n++; end
    d1 = bus_if.blk_data_o;
    l1 = bus_if.blk_last_o;
    step();
    v2 = bus_if.blk_valid_o;
    d2 = bus_if.blk_data_o;
    l2 = bus_if.blk_last_o;
    step();
    bus_if.blk_ready_i = 1'b0;
    n_tests++; if (d1 !== exp1) begin n_fail++; $display("FAIL len56_blk0_data: got %h required %h", d1, exp1); end
    n_tests++; if (l1 !== 1'b0) begin n_fail++; $display("FAIL len56_blk0_last: got %b required 0", l1); end
    n_tests++; if (v2 !== 1'b1) begin n_fail++; $display("FAIL len56_no_bubble: blk_valid_o=%b required 1", v2); end
    n_tests++; if (d2 !== exp2) begin n_fail++; $display("FAIL len56_blk1_data: got %h required %h", d2, exp2); end
    n_tests++; if (l2 !== 1'b1) begin n_fail++; $display("FAIL len56_blk1_last: got %b required 1", l2); end
    n_tests++; if (bus_if.in_ready_o !== 1'b1) begin n_fail++; $display("FAIL len56_refill: in_ready_o=%b required 1", bus_if.in_ready_o); end
  endtask

  task automatic test_64();
    logic [511:0] d, exp;
    logic l;
    exp = '0;
    for (int i = 0; i < 64; i++) exp[511 - 8*i -: 8] = 8'(i + 1);
    send_msg(64, 1'b1);
    get_block(d, l);
    n_tests++; if (d !== exp) begin n_fail++; $display("FAIL len64_blk0_data: got %h required %h", d, exp); end
    n_tests++; if (l !== 1'b0) begin n_fail++; $display("FAIL len64_blk0_last: got %b required 0", l); end
    exp = '0;
    exp[511:504] = 8'h80;
    exp[63:0]    = 64'h200;
    get_block(d, l);
    n_tests++; if (d !== exp) begin n_fail++; $display("FAIL len64_blk1_data: got %h required %h", d, exp); end
    n_tests++; if (l !== 1'b1) begin n_fail++; $display("FAIL len64_blk1_last: got %b required 1", l); end
  endtask

  task automatic test_backpressure();
    logic [511:0] d, exp;
    logic l;
    exp = '0;
    exp[511:480] = 32'h61626380;
    exp[63:0]    = 64'h18;
    bus_if.blk_ready_i = 1'b0;
    send_beat(8'h61, 1'b0, 1'b0);
    send_beat(8'h62, 1'b0, 1'b0);
    send_beat(8'h63, 1'b1, 1'b0);
    for (int k = 0; k < 5; k++) begin
      n_tests++; if (bus_if.blk_valid_o !== 1'b1 || bus_if.blk_data_o !== exp || bus_if.blk_last_o !== 1'b1) begin
        n_fail++; $display("FAIL bp_hold_%0d: got %b/%h/%b required 1/%h/1", k, bus_if.blk_valid_o, bus_if.blk_data_o, bus_if.blk_last_o, exp);
      end
      n_tests++; if (bus_if.in_ready_o !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready_%0d: got %b required 0", k, bus_if.in_ready_o); end
      step();
    end
    get_block(d, l);
    n_tests++; if (d !== exp || l !== 1'b1) begin n_fail++; $display("FAIL bp_release: got %h/%b required %h/1", d, l, exp); end
  endtask

  task automatic test_reset_mid_message();
    send_msg(30, 1'b0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_tests++; if (bus_if.in_ready_o !== 1'b1 || bus_if.blk_valid_o !== 1'b0 || bus_if.blk_data_o !== 512'd0) begin
      n_fail++; $display("FAIL rst_mid_msg: ready/valid/data %b/%b/%h required 1/0/0", bus_if.in_ready_o, bus_if.blk_valid_o, bus_if.blk_data_o);
    end
    test_abc("abc_after_rst_msg");
  endtask

  task automatic test_reset_mid_block();
    send_msg(56, 1'b1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_tests++; if (bus_if.in_ready_o !== 1'b1 || bus_if.blk_valid_o !== 1'b0 || bus_if.blk_last_o !== 1'b0 || bus_if.blk_data_o !== 512'd0) begin
      n_fail++; $display("FAIL rst_mid_blk: ready/valid/last %b/%b/%b required 1/0/0", bus_if.in_ready_o, bus_if.blk_valid_o, bus_if.blk_last_o);
    end
    test_abc("abc_after_rst_blk");
  endtask

  initial begin
    rst                = 1'b1;
    bus_if.in_valid_i  = 1'b0;
    bus_if.in_data_i   = 8'h00;
    bus_if.in_last_i   = 1'b0;
    bus_if.in_empty_i  = 1'b0;
    bus_if.blk_ready_i = 1'b0;
    test_reset();
    test_empty();
    test_abc("abc");
    test_empty_ignored();
    test_55();
    test_back_to_back();
    test_64();
    test_backpressure();
    test_reset_mid_message();
    test_reset_mid_block();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
